// File: rtl/port_link_if.sv
`default_nettype none
// ============================================================================
// Module      : port_link_if
// Description : Bundle of the node-to-node channel signals. Holds the
//               upstream write side (wdata/wval/wresp) and the downstream
//               read side (rdata/rrdy/rresp/count).
//               slave  - view taken by the channel itself
//               master - view taken by the surrounding nodes / environment
// Revision    : 1.0 - initial release
// ============================================================================
interface port_link_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] wdata;   // write data from the upstream node
    logic             wval;    // write valid, held until wresp
    logic             wresp;   // write acknowledge pulse
    logic [WIDTH-1:0] rdata;   // head-of-FIFO word
    logic             rrdy;    // FIFO non-empty
    logic             rresp;   // pop request from the downstream node
    logic [CNT_W-1:0] count;   // current occupancy

    modport slave (
        input  wdata, wval, rresp,
        output wresp, rdata, rrdy, count
    );

    modport master (
        output wdata, wval, rresp,
        input  wresp, rdata, rrdy, count
    );
endinterface
`default_nettype wire

// File: rtl/port_link.sv
`default_nettype none
// ============================================================================
// Module      : port_link
// Description : One-direction inter-node channel. Words written by the
//               upstream node are buffered in a small FIFO and presented to
//               the downstream node. In rendezvous mode the write acknowledge
//               is withheld until the word has been consumed, giving
//               blocking-write semantics.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               link - port_link_if.slave (write side + read side + count)
// Parameters  : WIDTH      - data word width
//               DEPTH      - FIFO entries (power of two, >= 1)
//               RENDEZVOUS - 1: ack on consumption, 0: ack on buffer accept
// Revision    : 1.0 - initial release
// ============================================================================
module port_link #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 2,
    parameter int RENDEZVOUS = 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    port_link_if.slave  link
);

    localparam int                PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    // Storage: data plus a per-entry tag marking words whose writer is
    // still blocked waiting for consumption.
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] tag_q;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_inc, rd_ptr_inc;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rrdy_q, rrdy_d;
    logic             wresp_q, wresp_d;
    logic             pending_q, pending_d;

    logic             push;
    logic             pop;
    logic             pop_tagged;

    // Pointer wrap: power-of-two depth wraps by natural overflow; a single
    // entry FIFO keeps both pointers pinned at zero.
    generate
        if (DEPTH == 1) begin : g_ptr_single
            assign wr_ptr_inc = '0;
            assign rd_ptr_inc = '0;
        end else begin : g_ptr_wrap
            assign wr_ptr_inc = wr_ptr_q + PTR_W'(1);
            assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);
        end
    endgenerate

    // The wresp_q term keeps the writer's still-held word from being taken a
    // second time in the acknowledge cycle. Fullness is judged on the current
    // count only, so a same-cycle pop never frees room for a push.
    assign push       = link.wval & ~wresp_q & ~pending_q & (count_q < DEPTH_C);
    assign pop        = link.rresp & rrdy_q;
    assign pop_tagged = pop & tag_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        wresp_d   = 1'b0;
        pending_d = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_inc;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_inc;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        rrdy_d = (count_d != '0);

        if (RENDEZVOUS != 0) begin
            // Ack goes out the cycle after the tagged word leaves the FIFO.
            wresp_d   = pop_tagged;
            pending_d = (pending_q & ~pop_tagged) | push;
        end else begin
            wresp_d   = push;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rrdy_q    <= 1'b0;
            wresp_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rrdy_q    <= rrdy_d;
            wresp_q   <= wresp_d;
            pending_q <= pending_d;
        end
    end

    // Storage needs no reset: an entry is only ever read after it has been
    // written since the last reset, and its tag is rewritten with it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= link.wdata;
            tag_q[wr_ptr_q] <= (RENDEZVOUS != 0);
        end
    end

    assign link.wresp = wresp_q;
    assign link.rrdy  = rrdy_q;
    assign link.count = count_q;
    assign link.rdata = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_port_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_port_link
// Description : Self-checking bench for port_link. One rendezvous instance
//               and one buffered instance share clock and reset. Read data is
//               checked by a scoreboard monitor; handshake timing, occupancy
//               and reset behaviour are checked at fixed cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_port_link;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;

    port_link_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ifr ();
    port_link_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ifb ();

    port_link #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RENDEZVOUS(1)) u_rdv (
        .clk  (clk),
        .rst  (rst),
        .link (ifr)
    );

    port_link #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RENDEZVOUS(0)) u_buf (
        .clk  (clk),
        .rst  (rst),
        .link (ifb)
    );

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] expr[$];
    logic [WIDTH-1:0] expb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Buffered-side write: hold the word until wresp is seen, then drop wval.
    task automatic wr_b(input logic [WIDTH-1:0] d, input int lat);
        int n;
        n = 0;
        ifb.wdata = d;
        ifb.wval  = 1'b1;
        expb.push_back(d);
        do begin
            tick();
            n++;
        end while (!ifb.wresp && n < 20);
        chk("buf_wr_latency", n, lat);
        ifb.wval = 1'b0;
    endtask

    // Scoreboard monitor: every accepted pop must deliver the next expected word.
    always @(negedge clk) begin
        if (!rst) begin
            if (ifr.rrdy && ifr.rresp) begin
                if (expr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rdv_unexpected_pop: got %0h expected none", ifr.rdata);
                end else begin
                    chk("rdv_rdata", ifr.rdata, expr.pop_front());
                end
            end
            if (ifb.rrdy && ifb.rresp) begin
                if (expb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL buf_unexpected_pop: got %0h expected none", ifb.rdata);
                end else begin
                    chk("buf_rdata", ifb.rdata, expb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifr.wval = 1'b0; ifr.wdata = '0; ifr.rresp = 1'b0;
        ifb.wval = 1'b0; ifb.wdata = '0; ifb.rresp = 1'b0;
        rst = 1'b0;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_async_rdv_rrdy",  ifr.rrdy,  0);
        chk("rst_async_rdv_wresp", ifr.wresp, 0);
        chk("rst_async_rdv_count", ifr.count, 0);
        chk("rst_async_buf_rrdy",  ifb.rrdy,  0);
        chk("rst_async_buf_count", ifb.count, 0);
        repeat (3) begin
            tick();
            chk("rst_hold_rdv", {ifr.rrdy, ifr.wresp, ifr.count}, 0);
            chk("rst_hold_buf", {ifb.rrdy, ifb.wresp, ifb.count}, 0);
        end
        rst = 1'b0;
        tick();

        // Rendezvous: ack withheld until consumption
        ifr.wdata = 8'h5A;
        ifr.wval  = 1'b1;
        expr.push_back(8'h5A);
        tick();
        chk("rdv_push_rrdy",  ifr.rrdy,  1);
        chk("rdv_push_rdata", ifr.rdata, 8'h5A);
        chk("rdv_push_count", ifr.count, 1);
        chk("rdv_push_wresp", ifr.wresp, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rdv_hold_wresp", ifr.wresp, 0);
            chk("rdv_hold_count", ifr.count, 1);
        end
        ifr.rresp = 1'b1;
        tick();
        chk("rdv_pop_wresp", ifr.wresp, 1);
        chk("rdv_pop_rrdy",  ifr.rrdy,  0);
        chk("rdv_pop_count", ifr.count, 0);
        ifr.rresp = 1'b0;
        ifr.wval  = 1'b0;
        tick();
        chk("rdv_wresp_pulse", ifr.wresp, 0);

        // Buffered: fill, block on full, simultaneous pop/push attempt
        wr_b(8'h01, 1);
        chk("buf_count_1", ifb.count, 1);
        wr_b(8'h02, 2);
        chk("buf_count_2", ifb.count, 2);
        ifb.wdata = 8'h03;
        ifb.wval  = 1'b1;
        expb.push_back(8'h03);
        repeat (3) begin
            tick();
            chk("buf_full_wresp", ifb.wresp, 0);
            chk("buf_full_count", ifb.count, 2);
        end
        ifb.rresp = 1'b1;
        tick();
        ifb.rresp = 1'b0;
        chk("buf_fullpop_count", ifb.count, 1);
        chk("buf_fullpop_rdata", ifb.rdata, 8'h02);
        chk("buf_fullpop_wresp", ifb.wresp, 0);
        tick();
        chk("buf_refill_count", ifb.count, 2);
        chk("buf_refill_wresp", ifb.wresp, 1);
        ifb.wval = 1'b0;
        tick();
        chk("buf_refill_pulse", ifb.wresp, 0);
        ifb.rresp = 1'b1;
        tick();
        tick();
        ifb.rresp = 1'b0;
        chk("buf_drain_count", ifb.count, 0);
        chk("buf_drain_rrdy",  ifb.rrdy,  0);

        // Reads on an empty FIFO are ignored
        ifb.rresp = 1'b1;
        repeat (5) begin
            tick();
            chk("buf_empty_count", ifb.count, 0);
            chk("buf_empty_rrdy",  ifb.rrdy,  0);
        end
        ifb.rresp = 1'b0;
        wr_b(8'h7F, 1);
        chk("buf_after_empty_rdata", ifb.rdata, 8'h7F);
        ifb.rresp = 1'b1;
        tick();
        ifb.rresp = 1'b0;
        chk("buf_after_empty_count", ifb.count, 0);

        // Reset mid-operation: buffered full, rendezvous pending
        wr_b(8'h11, 1);
        wr_b(8'h22, 2);
        ifb.wdata = 8'h33; ifb.wval = 1'b1;
        ifr.wdata = 8'h33; ifr.wval = 1'b1;
        tick();
        chk("mid_pre_rdv_count", ifr.count, 1);
        chk("mid_pre_buf_count", ifb.count, 2);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_rdv", {ifr.rrdy, ifr.wresp, ifr.count}, 0);
        chk("mid_rst_buf", {ifb.rrdy, ifb.wresp, ifb.count}, 0);
        expr.delete();
        expb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        expr.push_back(8'h33);
        expb.push_back(8'h33);
        tick();
        chk("mid_rel_rdv_rrdy",  ifr.rrdy,  1);
        chk("mid_rel_rdv_rdata", ifr.rdata, 8'h33);
        chk("mid_rel_rdv_count", ifr.count, 1);
        chk("mid_rel_rdv_wresp", ifr.wresp, 0);
        chk("mid_rel_buf_rdata", ifb.rdata, 8'h33);
        chk("mid_rel_buf_count", ifb.count, 1);
        chk("mid_rel_buf_wresp", ifb.wresp, 1);
        ifb.wval  = 1'b0;
        ifr.rresp = 1'b1;
        ifb.rresp = 1'b1;
        tick();
        ifr.rresp = 1'b0;
        ifb.rresp = 1'b0;
        chk("mid_pop_rdv_wresp", ifr.wresp, 1);
        chk("mid_pop_rdv_count", ifr.count, 0);
        chk("mid_pop_buf_count", ifb.count, 0);
        chk("mid_pop_buf_rrdy",  ifb.rrdy,  0);
        ifr.wval = 1'b0;
        tick();
        chk("mid_end_rdv_wresp", ifr.wresp, 0);
        chk("mid_end_rdv_count", ifr.count, 0);

        chk("scoreboard_empty", expr.size() + expb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/port_link.md
Name: port_link

Overview:
- Inter-node channel for one direction of a node port.
- Sits downstream of the execution path's write interface (outN/valN/wrespN) of one node and upstream of the read interface (inN/rrdyN/rrespN) of the adjacent node.
- Buffers words in a small FIFO.
- In rendezvous mode it withholds the write acknowledge until the reader consumes the word, which gives blocking-write port semantics.

Parameters:
- WIDTH, 8: data word width.
- DEPTH, 2: FIFO entries; a power of two, at least 1.
- RENDEZVOUS, 1: 1 = acknowledge the write on consumption; 0 = acknowledge on buffer accept.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state immediately.
- wdata  input  WIDTH  write data from the upstream node; held stable while wval=1.
- wval  input  1  write valid; held until wresp is observed.
- wresp  output  1  write acknowledge; registered single-cycle pulse.
- rdata  output  WIDTH  head-of-FIFO word to the downstream node.
- rrdy  output  1  read ready; FIFO is non-empty.
- rresp  input  1  read response; pops the head at the edge when rrdy=1.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async, rst=1): FIFO pointers=0, count=0, rrdy=0, wresp=0, pending=0. rdata is don't-care while rrdy=0. Effect is immediate, with no clock edge required. After rst deasserts, normal operation starts at the next rising edge.
- Push condition (both modes): wval=1 & wresp=0 & pending=0 & count<DEPTH, sampled at the edge.
  - A full FIFO blocks the push even if rresp pops in the same cycle. The push is taken at the next edge.
  - The wresp=0 term stops the writer's held word from being pushed twice.
- Push timing: a word sampled at edge N is visible as rrdy=1 / rdata in cycle N+1 if the FIFO was empty.
- Buffered mode (RENDEZVOUS=0):
  - wresp=1 in cycle N+1, exactly one cycle.
  - The writer drops wval or presents the next word after seeing wresp.
  - Maximum throughput is one word per 2 cycles.
- Rendezvous mode (RENDEZVOUS=1):
  - A push sets pending=1 and marks that entry as tagged. No further pushes while pending=1, so occupancy is at most 1 and DEPTH is effectively 1.
  - When the tagged entry is popped at edge M, wresp=1 in cycle M+1 for one cycle, and pending clears at edge M.
- Pop: rresp=1 & rrdy=1 at an edge advances the read pointer and decrements count. rrdy/rdata update in the following cycle.
  - rresp while rrdy=0 is ignored: no pointer movement, no count underflow.
- Simultaneous push and pop (count between 1 and DEPTH-1): both happen and count is unchanged.
- Pointers wrap modulo DEPTH. count covers 0..DEPTH inclusive.
- Reset mid-operation:
  - Buffered words and pending state are discarded; no wresp is issued for them.
  - A writer still holding wval is re-accepted after reset release, per the push rules.
- wresp, rrdy and count are registered outputs. There is no combinational path from wval/rresp to any output, which keeps node-to-node timing loop-free.

Test Plan:
- Reset check: rst=1 asynchronously with no clock edge -> rrdy=0, wresp=0, count=0 immediately. Hold 3 cycles; outputs stay cleared.
- Rendezvous, RENDEZVOUS=1: wval=1, wdata=0x5A at edge 1 -> cycle 2 rrdy=1, rdata=0x5A, count=1. Hold wval 10 cycles -> wresp stays 0 and count stays 1 (no duplicate push). rresp=1 at edge 12 -> wresp=1 in cycle 13 only, rrdy=0, count=0.
- Buffered, RENDEZVOUS=0, DEPTH=2: write 0x01 then 0x02 with no reads -> each gets a 1-cycle wresp, count=2. Third write 0x03 held -> wresp=0, count=2. One rresp pop -> rdata=0x02 next cycle; 0x03 accepted at the following edge; then wresp pulses.
- Full with simultaneous pop: count=2, wval=1 and rresp=1 at the same edge -> pop only, count=1. Push at the next edge -> count=2, wresp pulse one cycle later.
- Empty read: rresp=1 for 5 cycles with count=0 -> count stays 0, rrdy=0. The next write 0x7F is read back as 0x7F (pointers not corrupted).
- Reset mid-operation: count=2 in buffered mode, or pending=1 in rendezvous mode; assert rst between edges -> rrdy=0, count=0, wresp=0 immediately. After release, a held wval=1, wdata=0x33 is pushed at the first edge and rdata=0x33.
